// File: rtl/rdata_aligner.sv
// rdata_aligner: pairs golden and DUV read beats in arrival order and holds each aligned pair for the checker
module rdata_aligner #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     golden_valid,
  input  logic [DATA_W-1:0]        golden_rdata,
  input  logic                     duv_valid,
  input  logic [DATA_W-1:0]        duv_rdata,
  output logic [DATA_W-1:0]        golden_HRDATA,
  output logic [DATA_W-1:0]        duv_HRDATA,
  output logic                     pair_valid,
  output logic [$clog2(DEPTH):0]   golden_level,
  output logic [$clog2(DEPTH):0]   duv_level,
  output logic [15:0]              pair_count,
  output logic                     overflow_err,
  output logic                     timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [DATA_W-1:0] g_mem [DEPTH];
  logic [DATA_W-1:0] d_mem [DEPTH];
  logic [AW-1:0] g_wp, g_rp, d_wp, d_rp;
  logic [TW-1:0] tcnt;
  logic pop, g_push, d_push, idle;
  // pop and push decisions come from registered levels; a full queue still accepts when it pops in the same cycle
  always_comb begin
    pop    = (golden_level != '0) && (duv_level != '0);
    g_push = golden_valid && ((golden_level != LW'(DEPTH)) || pop);
    d_push = duv_valid && ((duv_level != LW'(DEPTH)) || pop);
    idle   = (golden_level == '0) && (duv_level == '0);
  end
  // queue storage carries no reset; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (!reset && g_push) g_mem[g_wp] <= golden_rdata;
    if (!reset && d_push) d_mem[d_wp] <= duv_rdata;
  end
  // pointers, levels, aligned outputs, counters and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      g_wp          <= '0;
      g_rp          <= '0;
      d_wp          <= '0;
      d_rp          <= '0;
      golden_level  <= '0;
      duv_level     <= '0;
      golden_HRDATA <= '0;
      duv_HRDATA    <= '0;
      pair_valid    <= 1'b0;
      pair_count    <= '0;
      overflow_err  <= 1'b0;
      timeout_err   <= 1'b0;
      tcnt          <= '0;
    end else begin
      g_wp          <= g_push ? g_wp + AW'(1) : g_wp;
      d_wp          <= d_push ? d_wp + AW'(1) : d_wp;
      g_rp          <= pop ? g_rp + AW'(1) : g_rp;
      d_rp          <= pop ? d_rp + AW'(1) : d_rp;
      golden_level  <= golden_level + LW'(g_push) - LW'(pop);
      duv_level     <= duv_level + LW'(d_push) - LW'(pop);
      golden_HRDATA <= pop ? g_mem[g_rp] : golden_HRDATA;
      duv_HRDATA    <= pop ? d_mem[d_rp] : duv_HRDATA;
      pair_valid    <= pop;
      pair_count    <= pair_count + 16'(pop && (pair_count != 16'hFFFF));
      overflow_err  <= overflow_err | (golden_valid && !g_push) | (duv_valid && !d_push);
      timeout_err   <= timeout_err | (tcnt == TW'(TIMEOUT));
      tcnt          <= (pop || idle) ? '0 : (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + TW'(1);
    end
  end
endmodule

// File: tb/tb_rdata_aligner.sv
// tb_rdata_aligner: randomized and directed checks of rdata_aligner against a queue-based reference model
module tb_rdata_aligner;
  localparam int DW = 32;
  localparam int DP = 8;
  localparam int TO = 16;
  localparam int LW = $clog2(DP) + 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic golden_valid = 1'b0;
  logic [DW-1:0] golden_rdata = '0;
  logic duv_valid = 1'b0;
  logic [DW-1:0] duv_rdata = '0;
  logic [DW-1:0] golden_HRDATA, duv_HRDATA;
  logic pair_valid;
  logic [LW-1:0] golden_level, duv_level;
  logic [15:0] pair_count;
  logic overflow_err, timeout_err;
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] gq[$];
  logic [DW-1:0] dq[$];
  logic [DW-1:0] m_g, m_d;
  logic m_pv, m_ovf, m_to;
  int m_cnt, m_tc;

  rdata_aligner #(.DATA_W(DW), .DEPTH(DP), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .golden_valid(golden_valid), .golden_rdata(golden_rdata),
    .duv_valid(duv_valid), .duv_rdata(duv_rdata),
    .golden_HRDATA(golden_HRDATA), .duv_HRDATA(duv_HRDATA),
    .pair_valid(pair_valid), .golden_level(golden_level), .duv_level(duv_level),
    .pair_count(pair_count), .overflow_err(overflow_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic gv, input logic [DW-1:0] gd, input logic dv, input logic [DW-1:0] dd);
    bit pop, g_full, d_full, one_side;
    reset = r; golden_valid = gv; golden_rdata = gd; duv_valid = dv; duv_rdata = dd;
    @(posedge clk);
    if (r) begin
      gq.delete(); dq.delete();
      m_g = '0; m_d = '0; m_pv = 0; m_ovf = 0; m_to = 0; m_cnt = 0; m_tc = 0;
    end else begin
      pop = gq.size() > 0 && dq.size() > 0;
      g_full = gq.size() == DP;
      d_full = dq.size() == DP;
      one_side = (gq.size() > 0) != (dq.size() > 0);
      if (m_tc == TO) m_to = 1;
      m_tc = (pop || !one_side) ? 0 : (m_tc < TO ? m_tc + 1 : m_tc);
      m_pv = pop;
      if (pop) begin
        m_g = gq.pop_front();
        m_d = dq.pop_front();
        if (m_cnt < 16'hFFFF) m_cnt++;
      end
      if (gv) begin if (!g_full || pop) gq.push_back(gd); else m_ovf = 1; end
      if (dv) begin if (!d_full || pop) dq.push_back(dd); else m_ovf = 1; end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 32'h1234_5678, 1, 32'h8765_4321);
    step(1, 0, 0, 0, 0);
    n_cmp++; if (golden_HRDATA !== 32'h0 || duv_HRDATA !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0/0", golden_HRDATA, duv_HRDATA); end
    n_cmp++; if (golden_level !== 0 || duv_level !== 0) begin n_err++; $display("FAIL reset_levels: got %0d/%0d want 0/0", golden_level, duv_level); end
    n_cmp++; if ({pair_valid, overflow_err, timeout_err} !== 3'b000 || pair_count !== 16'h0) begin n_err++; $display("FAIL reset_flags: got pv%b ov%b to%b cnt%0d want all 0", pair_valid, overflow_err, timeout_err, pair_count); end
  endtask

  task automatic test_lockstep();
    int k = 0;
    step(1, 0, 0, 0, 0);
    for (int e = 1; e <= 8; e++) begin
      if (e <= 4) step(0, 1, 32'hA5A5_0000 + DW'(e), 1, 32'hA5A5_0000 + DW'(e));
      else step(0, 0, 0, 0, 0);
      n_cmp++; if (pair_valid !== (e >= 2 && e <= 5)) begin n_err++; $display("FAIL lockstep_pv edge%0d: got %b want %b", e, pair_valid, (e >= 2 && e <= 5)); end
      if (pair_valid) begin
        k++;
        n_cmp++; if (golden_HRDATA !== 32'hA5A5_0000 + DW'(k) || duv_HRDATA !== 32'hA5A5_0000 + DW'(k)) begin n_err++; $display("FAIL lockstep_data pair%0d: got %h/%h want %h", k, golden_HRDATA, duv_HRDATA, 32'hA5A5_0000 + DW'(k)); end
      end
    end
    n_cmp++; if (pair_count !== 16'd4 || golden_level !== 0 || duv_level !== 0) begin n_err++; $display("FAIL lockstep_end: got cnt%0d lv%0d/%0d want 4 0/0", pair_count, golden_level, duv_level); end
  endtask

  task automatic test_skew();
    logic [DW-1:0] w[2];
    int k = 0;
    w[0] = 32'h1111_1111; w[1] = 32'h2222_2222;
    step(1, 0, 0, 0, 0);
    step(0, 1, w[0], 0, 0);
    step(0, 1, w[1], 0, 0);
    n_cmp++; if (golden_level !== 2 || duv_level !== 0) begin n_err++; $display("FAIL skew_level: got %0d/%0d want 2/0", golden_level, duv_level); end
    for (int c = 2; c < 10; c++) step(0, 0, 0, 0, 0);
    for (int c = 0; c < 8 && k < 2; c++) begin
      step(0, 0, 0, c < 2, c < 2 ? w[c] : 32'h0);
      if (pair_valid) begin
        n_cmp++; if (golden_HRDATA !== w[k] || duv_HRDATA !== w[k]) begin n_err++; $display("FAIL skew_pair%0d: got %h/%h want %h", k, golden_HRDATA, duv_HRDATA, w[k]); end
        k++;
      end
    end
    n_cmp++; if (k !== 2) begin n_err++; $display("FAIL skew_pairs: got %0d want 2", k); end
    n_cmp++; if (timeout_err !== 1'b0 || overflow_err !== 1'b0) begin n_err++; $display("FAIL skew_flags: got to%b ov%b want 0 0", timeout_err, overflow_err); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] gw[9];
    logic [DW-1:0] dw[8];
    int k = 0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin gw[i] = $urandom; step(0, 1, gw[i], 0, 0); end
    n_cmp++; if (golden_level !== 8 || overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_full: got lv%0d ov%b want 8 1", golden_level, overflow_err); end
    for (int c = 0; c < 20 && k < 8; c++) begin
      if (c < 8) dw[c] = $urandom;
      step(0, 0, 0, c < 8, c < 8 ? dw[c] : 32'h0);
      if (pair_valid) begin
        n_cmp++; if (golden_HRDATA !== gw[k] || duv_HRDATA !== dw[k]) begin n_err++; $display("FAIL ovf_pair%0d: got %h/%h want %h/%h", k, golden_HRDATA, duv_HRDATA, gw[k], dw[k]); end
        k++;
      end
    end
    n_cmp++; if (k !== 8 || golden_level !== 0 || overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_drain: got pairs%0d lv%0d ov%b want 8 0 1", k, golden_level, overflow_err); end
  endtask

  task automatic test_full_pop();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, DW'(i), 0, 0);
    step(0, 0, 0, 1, 32'hD0);
    step(0, 1, 32'h99, 1, 32'hD1);
    n_cmp++; if (golden_level !== 8 || duv_level !== 1 || overflow_err !== 1'b0) begin n_err++; $display("FAIL full_pop: got lv%0d/%0d ov%b want 8/1 0", golden_level, duv_level, overflow_err); end
    n_cmp++; if (pair_valid !== 1'b1 || golden_HRDATA !== 32'h0 || duv_HRDATA !== 32'hD0) begin n_err++; $display("FAIL full_pop_pair: got pv%b %h/%h want 1 0/d0", pair_valid, golden_HRDATA, duv_HRDATA); end
  endtask

  task automatic test_timeout();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %b want 0", timeout_err); end
    for (int i = 0; i < TO + 2; i++) step(0, 0, 0, 0, 0);
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_set: got %b want 1", timeout_err); end
    step(0, 1, 32'hCAFE_0001, 0, 0);
    step(0, 0, 0, 0, 0);
    n_cmp++; if (pair_valid !== 1'b1 || duv_HRDATA !== 32'hDEAD_BEEF || golden_HRDATA !== 32'hCAFE_0001 || timeout_err !== 1'b1) begin n_err++; $display("FAIL timeout_pair: got pv%b %h/%h to%b want 1 cafe0001/deadbeef 1", pair_valid, golden_HRDATA, duv_HRDATA, timeout_err); end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 1, 32'h0BAD_0BAD);
    step(0, 0, 0, 1, 32'h0BAD_0BAD);
    for (int i = 0; i < 9; i++) step(0, 1, 32'h0BAD_0000 + DW'(i), 0, 0);
    step(1, 1, 32'h0BAD_FFFF, 1, 32'h0BAD_FFFF);
    n_cmp++; if (golden_level !== 0 || duv_level !== 0 || golden_HRDATA !== 0 || duv_HRDATA !== 0) begin n_err++; $display("FAIL midrst_state: got lv%0d/%0d %h/%h want 0", golden_level, duv_level, golden_HRDATA, duv_HRDATA); end
    n_cmp++; if (overflow_err !== 1'b0 || timeout_err !== 1'b0 || pair_count !== 0) begin n_err++; $display("FAIL midrst_flags: got ov%b to%b cnt%0d want 0", overflow_err, timeout_err, pair_count); end
    step(0, 1, 32'h5EED_0001, 1, 32'h5EED_0002);
    step(0, 0, 0, 0, 0);
    n_cmp++; if (pair_valid !== 1'b1 || golden_HRDATA !== 32'h5EED_0001 || duv_HRDATA !== 32'h5EED_0002) begin n_err++; $display("FAIL midrst_pair: got pv%b %h/%h want 1 5eed0001/5eed0002", pair_valid, golden_HRDATA, duv_HRDATA); end
    step(0, 0, 0, 0, 0);
    n_cmp++; if (pair_valid !== 1'b0 || pair_count !== 1 || golden_level !== 0) begin n_err++; $display("FAIL midrst_after: got pv%b cnt%0d lv%0d want 0 1 0", pair_valid, pair_count, golden_level); end
  endtask

  task automatic test_random();
    int gp, dp;
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      gp = ((c / 40) % 3 == 1) ? 90 : 45;
      dp = ((c / 40) % 3 == 2) ? 5 : 45;
      step(0, $urandom_range(99) < gp, $urandom, $urandom_range(99) < dp, $urandom);
      n_cmp++;
      if (pair_valid !== m_pv || golden_level !== LW'(gq.size()) || duv_level !== LW'(dq.size()) ||
          pair_count !== 16'(m_cnt) || overflow_err !== m_ovf || timeout_err !== m_to ||
          (m_pv && (golden_HRDATA !== m_g || duv_HRDATA !== m_d))) begin
        n_err++;
        $display("FAIL random c%0d: got pv%b lv%0d/%0d cnt%0d ov%b to%b %h/%h want pv%b lv%0d/%0d cnt%0d ov%b to%b %h/%h",
                 c, pair_valid, golden_level, duv_level, pair_count, overflow_err, timeout_err, golden_HRDATA, duv_HRDATA,
                 m_pv, gq.size(), dq.size(), m_cnt, m_ovf, m_to, m_g, m_d);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_lockstep();
    test_skew();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
